// File: rtl/iob_cache_axi_read_arbiter_if.sv
// Signal bundle between the line-fill requesters, the read arbiter and the memory AXI read port.
// The master modport is the arbiter's view: it masters the external AXI read channel and
// answers the requesters. The slave modport is the opposite view (requesters plus memory).
interface iob_cache_axi_read_arbiter_if #(
    parameter int N_M        = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
);
    // requester side
    logic [N_M-1:0]            s_arvalid_i;
    logic [N_M*AXI_ADDR_W-1:0] s_araddr_i;
    logic [N_M*AXI_LEN_W-1:0]  s_arlen_i;
    logic [N_M*3-1:0]          s_arsize_i;
    logic [N_M*2-1:0]          s_arburst_i;
    logic [N_M-1:0]            s_arready_o;
    logic [N_M-1:0]            s_rvalid_o;
    logic [AXI_DATA_W-1:0]     s_rdata_o;
    logic [1:0]                s_rresp_o;
    logic                      s_rlast_o;
    logic [N_M-1:0]            s_rready_i;

    // external memory side
    logic                      m_axi_arvalid_o;
    logic [AXI_ADDR_W-1:0]     m_axi_araddr_o;
    logic [AXI_LEN_W-1:0]      m_axi_arlen_o;
    logic [2:0]                m_axi_arsize_o;
    logic [1:0]                m_axi_arburst_o;
    logic [AXI_ID_W-1:0]       m_axi_arid_o;
    logic                      m_axi_arlock_o;
    logic [3:0]                m_axi_arcache_o;
    logic [2:0]                m_axi_arprot_o;
    logic [3:0]                m_axi_arqos_o;
    logic                      m_axi_arready_i;
    logic                      m_axi_rvalid_i;
    logic [AXI_DATA_W-1:0]     m_axi_rdata_i;
    logic [1:0]                m_axi_rresp_i;
    logic                      m_axi_rlast_i;
    logic                      m_axi_rready_o;

    modport master (
        input  s_arvalid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_arburst_i, s_rready_i,
        output s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o,
        output m_axi_arvalid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o,
        output m_axi_arid_o, m_axi_arlock_o, m_axi_arcache_o, m_axi_arprot_o, m_axi_arqos_o,
        input  m_axi_arready_i, m_axi_rvalid_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i,
        output m_axi_rready_o
    );

    modport slave (
        output s_arvalid_i, s_araddr_i, s_arlen_i, s_arsize_i, s_arburst_i, s_rready_i,
        input  s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o,
        input  m_axi_arvalid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o,
        input  m_axi_arid_o, m_axi_arlock_o, m_axi_arcache_o, m_axi_arprot_o, m_axi_arqos_o,
        output m_axi_arready_i, m_axi_rvalid_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i,
        input  m_axi_rready_o
    );
endinterface

// File: rtl/iob_cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between N_M cache line-fill masters.
// Exactly one burst is in flight; the grant is held from AR issue until the rlast beat.
// A beat counter checks the returned burst length against the latched arlen.
module iob_cache_axi_read_arbiter #(
    parameter int N_M        = 2,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1
) (
    input  logic                     clk_i,
    input  logic                     reset,
    iob_cache_axi_read_arbiter_if.master bus,
    output logic                     busy_o,
    output logic [$clog2(N_M)-1:0]   grant_o,
    output logic                     len_err_o
);
    localparam int GW = $clog2(N_M);
    localparam int CW = AXI_LEN_W + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       pick;
    logic                found;
    logic                arvalid_q;
    logic [AXI_LEN_W-1:0] arlen_q;
    logic [AXI_LEN_W-1:0] pick_len;
    logic [CW-1:0]       beat_cnt;
    logic [CW-1:0]       cnt_next;
    logic [CW-1:0]       beats_exp;
    logic                beat;

    // Round-robin search: first requesting index at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_len = '0;
        for (int i = 0; i < N_M; i++) begin
            if (!found && bus.s_arvalid_i[(int'(rr_ptr) + i) % N_M]) begin
                found = 1'b1;
                pick  = GW'((int'(rr_ptr) + i) % N_M);
            end
        end
        for (int k = 0; k < N_M; k++) begin
            if (int'(pick) == k) begin
                pick_len = bus.s_arlen_i[k*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    assign beat      = (state == DATA) && bus.m_axi_rvalid_i && bus.s_rready_i[grant];
    assign cnt_next  = (&beat_cnt) ? beat_cnt : beat_cnt + CW'(1);
    assign beats_exp = {1'b0, arlen_q} + CW'(1);

    // Main FSM: grant selection, burst tracking, round-robin advance and length checking.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            arlen_q   <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            busy_o    <= 1'b0;
            len_err_o <= 1'b0;
        end else begin
            len_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= pick;
                        arlen_q   <= pick_len;
                        arvalid_q <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_axi_arready_i) begin
                        beat_cnt  <= '0;
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt  <= cnt_next;
                        len_err_o <= bus.m_axi_rlast_i ? (cnt_next != beats_exp)
                                                       : (cnt_next == beats_exp);
                        if (bus.m_axi_rlast_i) begin
                            rr_ptr <= (grant == GW'(N_M - 1)) ? '0 : grant + GW'(1);
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Steer AR fields and handshakes to/from the granted requester only.
    always_comb begin
        bus.s_arready_o     = '0;
        bus.s_rvalid_o      = '0;
        bus.m_axi_rready_o  = 1'b0;
        bus.m_axi_araddr_o  = '0;
        bus.m_axi_arlen_o   = '0;
        bus.m_axi_arsize_o  = '0;
        bus.m_axi_arburst_o = '0;
        bus.m_axi_arid_o    = '0;
        if (state == ADDR) begin
            bus.s_arready_o[grant] = bus.m_axi_arready_i;
            bus.m_axi_arid_o       = AXI_ID_W'(grant);
            for (int k = 0; k < N_M; k++) begin
                if (int'(grant) == k) begin
                    bus.m_axi_araddr_o  = bus.s_araddr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
                    bus.m_axi_arlen_o   = bus.s_arlen_i[k*AXI_LEN_W +: AXI_LEN_W];
                    bus.m_axi_arsize_o  = bus.s_arsize_i[k*3 +: 3];
                    bus.m_axi_arburst_o = bus.s_arburst_i[k*2 +: 2];
                end
            end
        end
        if (state == DATA) begin
            bus.s_rvalid_o[grant] = bus.m_axi_rvalid_i;
            bus.m_axi_rready_o    = bus.s_rready_i[grant];
        end
    end

    assign bus.m_axi_arvalid_o = arvalid_q;
    assign bus.m_axi_arlock_o  = 1'b0;
    assign bus.m_axi_arcache_o = 4'b0011;
    assign bus.m_axi_arprot_o  = 3'b000;
    assign bus.m_axi_arqos_o   = 4'b0000;
    assign bus.s_rdata_o       = bus.m_axi_rdata_i;
    assign bus.s_rresp_o       = bus.m_axi_rresp_i;
    assign bus.s_rlast_o       = bus.m_axi_rlast_i;
    assign grant_o             = grant;
endmodule
